instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC and memory address width (min 8).
REQ-002 Parameter PC_STEP, default 4, PC increment per completed fetch.
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 Parameter CNT_W, default 16, width of the fetch counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 fetch_en  in  1  permits a new fetch to start.
REQ-008 pc_load  in  1  redirect strobe (branch/jump).
REQ-009 pc_load_val  in  ADDR_W  redirect target.
REQ-010 ir_ack  in  1  consumer has taken the held instruction.
REQ-011 mem_rd_data  in  32  memory read data.
REQ-012 mem_rd_valid  in  1  mem_rd_data valid this cycle.
REQ-013 mem_rd_req  out  1  one-cycle read request pulse.
REQ-014 mem_addr  out  ADDR_W  read address, equals pc_out.
REQ-015 pc_out  out  ADDR_W  current PC.
REQ-016 ir_valid  out  1  instruction register holds an unconsumed instruction.
REQ-017 opcode  out  6  IR[31:26]; rs  out  5  IR[25:21]; rt  out  5  IR[20:16]; offset  out  16  IR[15:0].
REQ-018 fetch_count  out  CNT_W  number of instructions delivered.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, HOLD, state register updated on clk.
REQ-020 IDLE: fetch_en=1 -> REQ; else remain.
REQ-021 REQ: mem_rd_req=1 for exactly this cycle, mem_addr=pc_out; -> WAIT unconditionally.
REQ-022 WAIT: on mem_rd_valid=1, IR <= mem_rd_data, pc_out <= pc_out + PC_STEP (mod 2^ADDR_W, wraps), ir_valid <= 1, fetch_count increments -> HOLD; otherwise remain, no timeout.
REQ-023 HOLD: ir_valid=1, IR frozen; ir_ack=1 -> ir_valid <= 0 and -> REQ if fetch_en=1 else IDLE; minimum ack-to-next-request latency one cycle.
REQ-024 Read latency: mem_rd_req to IR update is 1 + (memory wait cycles) clocks; fields are combinational slices of IR.
REQ-025 pc_load=1 in any state SHALL load pc_out <= pc_load_val on that edge, overriding the increment of REQ-022.
REQ-026 pc_load in REQ or WAIT SHALL set a discard flag; the next mem_rd_valid is dropped (IR, ir_valid, fetch_count unchanged), then -> REQ; flag clears on that response.
REQ-027 pc_load coincident with mem_rd_valid in WAIT: response dropped, PC = pc_load_val, -> REQ.
REQ-028 pc_load in HOLD: ir_valid <= 0 (instruction squashed, fetch_count unchanged), -> REQ if fetch_en else IDLE; simultaneous ir_ack ignored.
REQ-029 pc_load in IDLE: PC loaded, remains IDLE unless fetch_en.
REQ-030 mem_rd_valid outside WAIT SHALL be ignored.
REQ-031 fetch_count SHALL saturate at 2^CNT_W-1, not wrap.
REQ-032 fetch_en deassertion SHALL NOT abort an outstanding request; only new REQ entry is gated.

Reset
REQ-033 On reset=1, asynchronously: state=IDLE, pc_out=RESET_PC, IR=0, ir_valid=0, mem_rd_req=0, fetch_count=0, discard flag=0.
REQ-034 Reset mid-WAIT SHALL abandon the request; any later mem_rd_valid is ignored (state IDLE).
REQ-035 First mem_rd_req after release no earlier than the second clk edge with fetch_en=1.

Verification
REQ-036 Reset, fetch_en=1, memory returns 0x8C220004 two cycles after req -> opcode=0x23, rs=1, rt=2, offset=0x0004, ir_valid=1, pc_out=4, fetch_count=1.
REQ-037 Continuous fetch_en, ir_ack each HOLD cycle, 3 fetches -> mem_addr sequence 0,4,8, fetch_count=3.
REQ-038 pc_load=1, pc_load_val=0x100 during WAIT -> stale response dropped, next req at 0x100, IR from that response, pc_out=0x104.
REQ-039 ADDR_W=8, pc_out=0xFC, fetch completes -> pc_out=0x00.
REQ-040 CNT_W=2, 5 fetches -> fetch_count=3; reset asserted mid-WAIT -> all outputs at REQ-033 values, late mem_rd_valid has no effect.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch FSM; pulses mem_rd_req at pc_out (mem_addr), latches mem_rd_data into IR (opcode/rs/rt/offset), handles pc_load redirects, counts delivered instructions
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              ir_ack,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [15:0]       offset,
  output logic [CNT_W-1:0]  fetch_count
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] ir;
  logic discard, take, drop;
  assign drop = state == WAIT && mem_rd_valid && (discard || pc_load);
  assign take = state == WAIT && mem_rd_valid && !discard && !pc_load;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = fetch_en ? REQ : IDLE;
      REQ: state_n = WAIT;
      WAIT: state_n = drop ? REQ : take ? HOLD : WAIT;
      HOLD: state_n = (pc_load || ir_ack) ? (fetch_en ? REQ : IDLE) : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc_out <= RESET_PC;
      ir <= '0;
      discard <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc_out <= pc_load ? pc_load_val : take ? pc_out + ADDR_W'(PC_STEP) : pc_out;
      if (take) ir <= mem_rd_data;
      if (take && fetch_count != '1) fetch_count <= fetch_count + CNT_W'(1);
      discard <= (state == WAIT && mem_rd_valid) ? 1'b0 :
                 (pc_load && (state == REQ || state == WAIT)) ? 1'b1 : discard;
    end
  end
  assign mem_rd_req = state == REQ;
  assign mem_addr = pc_out;
  assign ir_valid = state == HOLD;
  assign opcode = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign offset = ir[15:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of a default instance and an 8-bit-address, 2-bit-counter instance sharing one stimulus
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fetch_en = 1'b0;
  logic pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;
  logic ir_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic mem_rd_valid = 1'b0;
  logic a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_pc;
  logic [7:0] b_addr, b_pc;
  logic [5:0] a_op, b_op;
  logic [4:0] a_rs, a_rt, b_rs, b_rt;
  logic [15:0] a_off, b_off, a_cnt;
  logic [1:0] b_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  instr_fetch_unit dut_a (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .ir_ack(ir_ack), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_rd_req(a_req),
    .mem_addr(a_addr), .pc_out(a_pc), .ir_valid(a_valid), .opcode(a_op), .rs(a_rs), .rt(a_rt),
    .offset(a_off), .fetch_count(a_cnt)
  );
  instr_fetch_unit #(.ADDR_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_load(pc_load), .pc_load_val(pc_load_val[7:0]),
    .ir_ack(ir_ack), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_rd_req(b_req),
    .mem_addr(b_addr), .pc_out(b_pc), .ir_valid(b_valid), .opcode(b_op), .rs(b_rs), .rt(b_rt),
    .offset(b_off), .fetch_count(b_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_pc", 64'(a_pc), 64'h0);
    chk("rst_req", 64'(a_req), 64'h0);
    chk("rst_valid", 64'(a_valid), 64'h0);
    chk("rst_cnt", 64'(a_cnt), 64'h0);
    chk("rst_op", 64'(a_op), 64'h0);
    reset = 1'b0;
    fetch_en = 1'b1;
    chk("no_early_req", 64'(a_req), 64'h0);
    tick();
    chk("req1", 64'(a_req), 64'h1);
    chk("addr1", 64'(a_addr), 64'h0);
    tick();
    chk("req_pulse", 64'(a_req), 64'h0);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h8C220004;
    tick();
    mem_rd_valid = 1'b0;
    chk("f1_op", 64'(a_op), 64'h23);
    chk("f1_rs", 64'(a_rs), 64'h1);
    chk("f1_rt", 64'(a_rt), 64'h2);
    chk("f1_off", 64'(a_off), 64'h4);
    chk("f1_valid", 64'(a_valid), 64'h1);
    chk("f1_pc", 64'(a_pc), 64'h4);
    chk("f1_cnt", 64'(a_cnt), 64'h1);
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hFFFFFFFF;
    tick();
    mem_rd_valid = 1'b0;
    chk("hold_ign_op", 64'(a_op), 64'h23);
    chk("hold_ign_cnt", 64'(a_cnt), 64'h1);
    chk("hold_valid", 64'(a_valid), 64'h1);
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    chk("req2", 64'(a_req), 64'h1);
    chk("addr2", 64'(a_addr), 64'h4);
    chk("ack_clr", 64'(a_valid), 64'h0);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h00000001;
    tick();
    mem_rd_valid = 1'b0;
    chk("f2_cnt", 64'(a_cnt), 64'h2);
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    chk("addr3", 64'(a_addr), 64'h8);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h04000002;
    tick();
    mem_rd_valid = 1'b0;
    chk("f3_cnt", 64'(a_cnt), 64'h3);
    chk("f3_pc", 64'(a_pc), 64'hC);
    chk("f3_op", 64'(a_op), 64'h1);
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_load_val = 32'h100;
    tick();
    pc_load = 1'b0;
    chk("redir_pc", 64'(a_pc), 64'h100);
    chk("redir_wait", 64'(a_req), 64'h0);
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hDEADBEEF;
    tick();
    mem_rd_valid = 1'b0;
    chk("drop_req", 64'(a_req), 64'h1);
    chk("drop_addr", 64'(a_addr), 64'h100);
    chk("drop_cnt", 64'(a_cnt), 64'h3);
    chk("drop_valid", 64'(a_valid), 64'h0);
    chk("drop_op", 64'(a_op), 64'h1);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h20010005;
    tick();
    mem_rd_valid = 1'b0;
    chk("f4_op", 64'(a_op), 64'h08);
    chk("f4_off", 64'(a_off), 64'h5);
    chk("f4_pc", 64'(a_pc), 64'h104);
    chk("f4_cnt", 64'(a_cnt), 64'h4);
    chk("b_sat4", 64'(b_cnt), 64'h3);
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    tick();
    pc_load = 1'b1;
    pc_load_val = 32'h200;
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hCAFEF00D;
    tick();
    pc_load = 1'b0;
    mem_rd_valid = 1'b0;
    chk("coin_pc", 64'(a_pc), 64'h200);
    chk("coin_req", 64'(a_req), 64'h1);
    chk("coin_cnt", 64'(a_cnt), 64'h4);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h30000007;
    tick();
    mem_rd_valid = 1'b0;
    chk("f5_off", 64'(a_off), 64'h7);
    chk("f5_pc", 64'(a_pc), 64'h204);
    chk("f5_cnt", 64'(a_cnt), 64'h5);
    chk("b_sat5", 64'(b_cnt), 64'h3);
    fetch_en = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 32'hFC;
    ir_ack = 1'b1;
    tick();
    pc_load = 1'b0;
    ir_ack = 1'b0;
    chk("squash_valid", 64'(a_valid), 64'h0);
    chk("squash_cnt", 64'(a_cnt), 64'h5);
    chk("squash_pc", 64'(a_pc), 64'hFC);
    tick();
    chk("idle_stay", 64'(a_req), 64'h0);
    fetch_en = 1'b1;
    tick();
    chk("wrap_addr", 64'(b_addr), 64'hFC);
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h11112222;
    tick();
    mem_rd_valid = 1'b0;
    chk("wrap_b_pc", 64'(b_pc), 64'h00);
    chk("wrap_a_pc", 64'(a_pc), 64'h100);
    chk("b_sat6", 64'(b_cnt), 64'h3);
    fetch_en = 1'b0;
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    chk("ack_idle_req", 64'(a_req), 64'h0);
    chk("ack_idle_valid", 64'(a_valid), 64'h0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h0C000009;
    tick();
    mem_rd_valid = 1'b0;
    chk("no_abort_cnt", 64'(a_cnt), 64'h7);
    chk("no_abort_valid", 64'(a_valid), 64'h1);
    fetch_en = 1'b1;
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc", 64'(a_pc), 64'h0);
    chk("async_cnt", 64'(a_cnt), 64'h0);
    chk("async_op", 64'(a_op), 64'h0);
    chk("async_b_cnt", 64'(b_cnt), 64'h0);
    fetch_en = 1'b0;
    tick();
    reset = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hFFFFFFFF;
    tick();
    mem_rd_valid = 1'b0;
    chk("late_valid", 64'(a_valid), 64'h0);
    chk("late_cnt", 64'(a_cnt), 64'h0);
    chk("late_op", 64'(a_op), 64'h0);
    chk("late_req", 64'(a_req), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
